e_mdu: RTL and testbench
========================

E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single pipeline clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Req, input, 1 bit: an exception or interrupt is taken this cycle; it suppresses the current E-stage MDU instruction.
REQ-004 SHALL have port E_MDUop, input, 4 bits, encoded as: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none.
REQ-005 SHALL have port E_V1, input, 32 bits: rs operand, already forwarded.
REQ-006 SHALL have port E_V2, input, 32 bits: rt operand, already forwarded.
REQ-007 SHALL have port E_Start, output, 1 bit: combinational; high when E_MDUop is 1-4, Req=0 and E_Busy=0.
REQ-008 SHALL have port E_Busy, output, 1 bit: registered; high while an operation is in flight.
REQ-009 SHALL have port E_MDU_out, output, 32 bits: combinational; HI for mfhi, LO for mflo, otherwise 0.
REQ-010 SHALL have port E_HI, output, 32 bits: the architectural HI register.
REQ-011 SHALL have port E_LO, output, 32 bits: the architectural LO register.

Function
REQ-012 SHALL latch E_V1, E_V2 and the op kind on any edge where E_Start=1, and load the cycle counter with 5 for mult/multu or 10 for div/divu.
REQ-013 SHALL drive E_Busy high from the edge after a start until the counter reaches 0; E_Busy SHALL equal (counter != 0), and the counter SHALL decrement by 1 per cycle while nonzero.
REQ-014 SHALL write HI/LO on the edge where the counter goes 1->0, and that same edge SHALL clear E_Busy, so new values are visible the following cycle.
REQ-015 SHALL compute mult as a signed 64-bit product and multu as unsigned; HI gets the upper 32 bits, LO the lower 32 bits.
REQ-016 SHALL compute div as signed, truncating toward zero with the remainder taking the dividend's sign; divu SHALL be unsigned; LO gets the quotient, HI the remainder.
REQ-017 SHALL, for signed 0x80000000 / 0xFFFFFFFF, set LO=0x80000000 and HI=0.
REQ-018 SHALL leave HI and LO unchanged for a divide by zero, with the full 10-cycle E_Busy period still observed.
REQ-019 SHALL write E_V1 into HI (mthi) or LO (mtlo) on the next edge, only when Req=0 and E_Busy=0.
REQ-020 SHALL ignore any op 1-4 or 7-8 that arrives while E_Busy=1; the hazard unit stalls these, and this block does not queue them.
REQ-021 SHALL let Req=1 suppress only the start or move presented in that cycle; an operation already in flight SHALL run to completion and commit HI/LO.
REQ-022 SHALL let mfhi/mflo read the current registered HI/LO regardless of E_Busy; stalling during busy is the hazard unit's job.
REQ-023 SHALL hold all registered state unchanged when E_MDUop is 0 or 9-15 and E_Busy=0.

Reset
REQ-024 SHALL, on reset assertion at any time including mid-operation, asynchronously clear HI, LO, the counter, E_Busy and the latched operands to 0; the in-flight result SHALL be discarded.
REQ-025 SHALL drive E_MDU_out=0 and E_Start=0 while reset is high, and SHALL accept a start on the first edge after reset deasserts.

Structure
REQ-026 SHALL take the MDU op encodings (0-8) and the latency constants MULT_CYCLES=5 and DIV_CYCLES=10 from the shared package also used by the decoder and the hazard unit.
REQ-027 SHALL be a single module with no sub-modules; the multiply and divide are behavioural operators evaluated on the latched operands.

Verification
REQ-028 SHALL cover mult: V1=0xFFFFFFFE (-2), V2=3 -> E_Busy high for exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA; with multu on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-029 SHALL cover div: V1=-7, V2=2 -> after 10 busy cycles LO=0xFFFFFFFD and HI=0xFFFFFFFF; with divu 7/0 -> HI/LO unchanged after 10 cycles.
REQ-030 SHALL cover overflow and moves: div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; then mthi 0x12345678 -> mfhi in the next cycle returns 0x12345678.
REQ-031 SHALL cover Req: Req=1 together with mult -> E_Start=0, E_Busy stays 0, HI/LO unchanged; Req=1 at busy cycle 3 of a div -> the div still commits on schedule.
REQ-032 SHALL cover ignored ops: mtlo 0xAAAA or a second mult during busy -> ignored, and the original result commits unaltered.
REQ-033 SHALL cover reset: reset asserted mid-edge at busy cycle 2 of a mult -> E_Busy, HI and LO read 0 immediately, without waiting for a clock edge, and no late commit occurs.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: op encodings and latency constants used by the decoder, hazard unit and MDU.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_t;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MULT_CYCLES = 4'd5;
  localparam logic [CNT_W-1:0] DIV_CYCLES  = 4'd10;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic [CNT_W-1:0] op_cycles(input logic [3:0] op);
    return ((op == MDU_MULT) || (op == MDU_MULTU)) ? MULT_CYCLES : DIV_CYCLES;
  endfunction

  // Low 64 bits of a 64x64 product equal the 32x32 product for either signedness.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult (5) / div (10) with HI/LO commit on the last busy edge.
// Moves to HI/LO and new starts are accepted only when idle; Req suppresses only this cycle's start or move.
module e_mdu
  import e_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  E_MDUop,
  input  logic [31:0] E_V1,
  input  logic [31:0] E_V2,
  output logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_MDU_out,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  logic [CNT_W-1:0] cnt_q;
  mdu_op_t          op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic [63:0]      prod;
  logic [31:0]      quo;
  logic [31:0]      rem;
  logic [31:0]      rd_val;

  assign E_Busy  = (cnt_q != '0);
  assign E_Start = !reset && !Req && !E_Busy && is_muldiv(E_MDUop);
  assign E_HI    = hi_q;
  assign E_LO    = lo_q;

  always_comb begin
    prod = mul64(a_q, b_q, op_q == MDU_MULT);
    quo  = '0;
    rem  = '0;
    if (op_q == MDU_DIV) begin
      // Signed overflow case has no representable quotient; fix it explicitly.
      if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
        quo = 32'h8000_0000;
        rem = '0;
      end else if (b_q != '0) begin
        quo = $unsigned($signed(a_q) / $signed(b_q));
        rem = $unsigned($signed(a_q) % $signed(b_q));
      end
    end else if (b_q != '0) begin
      quo = a_q / b_q;
      rem = a_q % b_q;
    end
  end

  always_comb begin
    rd_val = '0;
    if (!reset) begin
      if (E_MDUop == MDU_MFHI)      rd_val = hi_q;
      else if (E_MDUop == MDU_MFLO) rd_val = lo_q;
    end
  end
  assign E_MDU_out = rd_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= MDU_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (E_Start) begin
      a_q   <= E_V1;
      b_q   <= E_V2;
      op_q  <= mdu_op_t'(E_MDUop);
      cnt_q <= op_cycles(E_MDUop);
    end else if (E_Busy) begin
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == 4'd1) begin
        if (op_q == MDU_MULT || op_q == MDU_MULTU) begin
          hi_q <= prod[63:32];
          lo_q <= prod[31:0];
        end else if (b_q != '0) begin
          hi_q <= rem;
          lo_q <= quo;
        end
      end
    end else if (!Req) begin
      if (E_MDUop == MDU_MTHI) hi_q <= E_V1;
      else if (E_MDUop == MDU_MTLO) lo_q <= E_V1;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed + randomized bench for e_mdu against an arithmetic HI/LO reference model.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic [3:0]  E_MDUop;
  logic [31:0] E_V1;
  logic [31:0] E_V2;
  logic        E_Start;
  logic        E_Busy;
  logic [31:0] E_MDU_out;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] mhi;
  logic [31:0] mlo;

  localparam int INJ_NONE = 0, INJ_REQ = 1, INJ_MTLO = 2, INJ_MULT = 3;

  e_mdu dut (
    .clk(clk), .reset(reset), .Req(Req), .E_MDUop(E_MDUop), .E_V1(E_V1), .E_V2(E_V2),
    .E_Start(E_Start), .E_Busy(E_Busy), .E_MDU_out(E_MDU_out), .E_HI(E_HI), .E_LO(E_LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: wide integer arithmetic, quotient truncates toward zero.
  task automatic model_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p, q, r;
    longint unsigned pu, qu, ru;
    case (op)
      4'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        mhi = p[63:32]; mlo = p[31:0];
      end
      4'd2: begin
        pu = longint'(a) * longint'(b);
        mhi = pu[63:32]; mlo = pu[31:0];
      end
      4'd3: if (b != 0) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) - q * longint'($signed(b));
        mlo = q[31:0]; mhi = r[31:0];
      end
      4'd4: if (b != 0) begin
        qu = longint'(a) / longint'(b);
        ru = longint'(a) - qu * longint'(b);
        mlo = qu[31:0]; mhi = ru[31:0];
      end
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at a negedge after the op has committed.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input int inj_at);
    int n;
    int exp_cyc;
    E_MDUop = op; E_V1 = a; E_V2 = b; Req = 1'b0;
    #1 check("start", 32'(E_Start), 32'd1);
    @(negedge clk);
    E_MDUop = 4'd0; E_V1 = $urandom; E_V2 = $urandom;
    exp_cyc = (op <= 4'd2) ? 5 : 10;
    model_muldiv(op, a, b);
    n = 0;
    while (E_Busy && n < 40) begin
      n++;
      if (n == inj_at) begin
        if (inj == INJ_REQ) Req = 1'b1;
        if (inj == INJ_MTLO) begin E_MDUop = 4'd8; E_V1 = 32'h0000_AAAA; end
        if (inj == INJ_MULT) begin
          E_MDUop = 4'd1; E_V1 = $urandom; E_V2 = $urandom;
          #1 check("start_while_busy", 32'(E_Start), 32'd0);
        end
      end
      @(negedge clk);
      Req = 1'b0; E_MDUop = 4'd0;
    end
    check("busy_cycles", n, exp_cyc);
    check("hi", E_HI, mhi);
    check("lo", E_LO, mlo);
  endtask

  task automatic do_move(input logic [3:0] op, input logic [31:0] v);
    E_MDUop = op; E_V1 = v;
    @(negedge clk);
    E_MDUop = 4'd0;
    if (op == 4'd7) mhi = v; else mlo = v;
  endtask

  task automatic check_reads();
    E_MDUop = 4'd5; #1 check("mfhi", E_MDU_out, mhi);
    E_MDUop = 4'd6; #1 check("mflo", E_MDU_out, mlo);
    E_MDUop = 4'd0; #1 check("out_none", E_MDU_out, 32'd0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; Req = 1'b0; E_MDUop = 4'd1; E_V1 = 32'hFFFF_FFFE; E_V2 = 32'd3;
    mhi = 32'd0; mlo = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_start", 32'(E_Start), 32'd0);
    check("rst_busy", 32'(E_Busy), 32'd0);
    check("rst_hi", E_HI, 32'd0);
    check("rst_lo", E_LO, 32'd0);
    E_MDUop = 4'd5; #1 check("rst_out", E_MDU_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // First edge after reset release takes the start.
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, INJ_NONE, 0);
    check("mult_hi_const", E_HI, 32'hFFFF_FFFF);
    check("mult_lo_const", E_LO, 32'hFFFF_FFFA);
    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, INJ_NONE, 0);
    check("multu_hi_const", E_HI, 32'h0000_0002);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, INJ_NONE, 0);
    check("div_lo_const", E_LO, 32'hFFFF_FFFD);
    check("div_hi_const", E_HI, 32'hFFFF_FFFF);
    run_op(4'd4, 32'd7, 32'd0, INJ_NONE, 0);
    check("divu0_lo_const", E_LO, 32'hFFFF_FFFD);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, INJ_NONE, 0);
    check("ovf_lo_const", E_LO, 32'h8000_0000);
    check("ovf_hi_const", E_HI, 32'd0);
    do_move(4'd7, 32'h1234_5678);
    E_MDUop = 4'd5; #1 check("mthi_mfhi", E_MDU_out, 32'h1234_5678);
    E_MDUop = 4'd0;
    check_reads();

    // Req with a start: suppressed entirely.
    @(negedge clk);
    E_MDUop = 4'd1; E_V1 = 32'd1000; E_V2 = 32'd1000; Req = 1'b1;
    #1 check("req_start", 32'(E_Start), 32'd0);
    @(negedge clk);
    E_MDUop = 4'd0; Req = 1'b0;
    check("req_busy", 32'(E_Busy), 32'd0);
    check("req_hi", E_HI, mhi);
    check("req_lo", E_LO, mlo);
    // Req with a move: suppressed too.
    E_MDUop = 4'd8; E_V1 = 32'h5555_5555; Req = 1'b1;
    @(negedge clk);
    E_MDUop = 4'd0; Req = 1'b0;
    check("req_mtlo", E_LO, mlo);

    run_op(4'd3, 32'd100, 32'd7, INJ_REQ, 3);
    run_op(4'd1, 32'h0001_2345, 32'hFFFF_0003, INJ_MTLO, 2);
    run_op(4'd4, 32'hDEAD_BEEF, 32'd13, INJ_MULT, 4);
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, INJ_MTLO, 5);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) begin ra = ra >> 28; rb = $signed(rb) >>> 29; end
      run_op(rop, ra, rb, INJ_NONE, 0);
      if ($urandom_range(0, 1) == 1) do_move(4'($urandom_range(7, 8)), $urandom);
      check_reads();
      @(negedge clk);
    end

    // Async reset in the middle of a mult discards the result.
    do_move(4'd7, 32'hCAFE_F00D);
    do_move(4'd8, 32'h0BAD_BEEF);
    E_MDUop = 4'd1; E_V1 = 32'd7; E_V2 = 32'd9;
    @(negedge clk);
    E_MDUop = 4'd0;
    @(negedge clk);
    #2 reset = 1'b1; E_MDUop = 4'd1;
    #1;
    mhi = 32'd0; mlo = 32'd0;
    check("arst_busy", 32'(E_Busy), 32'd0);
    check("arst_hi", E_HI, 32'd0);
    check("arst_lo", E_LO, 32'd0);
    check("arst_start", 32'(E_Start), 32'd0);
    E_MDUop = 4'd6; #1 check("arst_out", E_MDU_out, 32'd0);
    @(negedge clk);
    reset = 1'b0; E_MDUop = 4'd0;
    repeat (12) @(negedge clk);
    check("late_busy", 32'(E_Busy), 32'd0);
    check("late_hi", E_HI, 32'd0);
    check("late_lo", E_LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
